regfile_wb_arb: RTL and testbench

- Writer side of the general-purpose register file: the single owner of the regfile write port (rfwe/rfwa/rfwd).
- Merges two write sources:
  - the in-order pipeline writeback, which has priority and no backpressure;
  - long-latency results (divider, cache-miss loads), which use a valid/ready handshake and wait in a small FIFO.
- Keeps a pending-write scoreboard so the hazard unit can stall reads of registers with outstanding long-latency results.

---
 rtl/regfile_wb_arb_if.sv | 29 ++
 rtl/regfile_wb_arb.sv | 132 +++++++++++++
 tb/tb_regfile_wb_arb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arb_if.sv
// Write-side bus of the register-file writeback arbiter: pipeline writeback,
// long-latency result handshake, issue tracking, scoreboard and regfile port.
interface regfile_wb_arb_if;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_wa;
  logic [31:0] ll_wd;
  logic        issue_valid;
  logic [4:0]  issue_wa;
  logic [31:0] busy_mask;
  logic        sb_err;
  logic        wb_stall_req;
  logic        rfwe;
  logic [4:0]  rfwa;
  logic [31:0] rfwd;

  modport master (
    output wb_we, wb_wa, wb_wd, ll_valid, ll_wa, ll_wd, issue_valid, issue_wa,
    input  ll_ready, busy_mask, sb_err, wb_stall_req, rfwe, rfwa, rfwd
  );

  modport slave (
    input  wb_we, wb_wa, wb_wd, ll_valid, ll_wa, ll_wd, issue_valid, issue_wa,
    output ll_ready, busy_mask, sb_err, wb_stall_req, rfwe, rfwa, rfwd
  );
endinterface

// File: rtl/regfile_wb_arb.sv
// Sole owner of the regfile write port: pipeline writeback wins, long-latency
// results queue in a FIFO. Optional starvation guard under WB_STARVE_GUARD_EN.
module regfile_wb_arb #(
  parameter int LL_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input logic             cpu_clk_50M,
  input logic             cpu_rst_n,
  regfile_wb_arb_if.slave bus
);
  localparam int          AW       = $clog2(LL_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(LL_DEPTH);

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ll_ent_t;

  ll_ent_t       mem [LL_DEPTH];
  ll_ent_t       head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          pipe_wr, push, pop, empty;
  logic [31:0]   busy, busy_nxt, set_mask, clr_mask;
  logic          sb_hit, sb_err_q;
  logic          rfwe_q;
  logic [4:0]    rfwa_q;
  logic [31:0]   rfwd_q;
  logic          stall_q;

  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign pipe_wr = bus.wb_we && (bus.wb_wa != 5'd0);
  assign push    = bus.ll_valid && bus.ll_ready;
  // Pop decision uses the pre-push count, so a fresh entry never bypasses.
  assign pop     = !pipe_wr && !empty;

  assign bus.ll_ready     = (count != FULL_CNT);
  assign bus.busy_mask    = busy;
  assign bus.sb_err       = sb_err_q;
  assign bus.wb_stall_req = stall_q;
  assign bus.rfwe         = rfwe_q;
  assign bus.rfwa         = rfwa_q;
  assign bus.rfwd         = rfwd_q;

  always_ff @(posedge cpu_clk_50M) begin
    if (push) mem[wr_ptr] <= '{wa: bus.ll_wa, wd: bus.ll_wd};
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      rfwe_q <= 1'b0;
      rfwa_q <= '0;
      rfwd_q <= '0;
    end else if (pipe_wr) begin
      rfwe_q <= 1'b1;
      rfwa_q <= bus.wb_wa;
      rfwd_q <= bus.wb_wd;
    end else if (pop && head.wa != 5'd0) begin
      rfwe_q <= 1'b1;
      rfwa_q <= head.wa;
      rfwd_q <= head.wd;
    end else begin
      rfwe_q <= 1'b0;
      rfwa_q <= '0;
      rfwd_q <= '0;
    end
  end

  // Set beats clear on the same bit; r0 never tracked.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.issue_valid && bus.issue_wa != 5'd0) set_mask = 32'd1 << bus.issue_wa;
    if (pop) clr_mask = 32'd1 << head.wa;
    busy_nxt = ((busy & ~clr_mask) | set_mask) & ~32'd1;
    sb_hit   = |(set_mask & busy & ~clr_mask);
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      busy     <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (sb_hit) sb_err_q <= 1'b1;
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int          SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [SW-1:0] starve, starve_nxt;

  always_comb begin
    starve_nxt = starve;
    if (empty || pop)              starve_nxt = '0;
    else if (starve != STARVE_TOP) starve_nxt = starve + SW'(1);
  end

  // Flop tracks (starve == STARVE_TOP) exactly, without a compare glitch.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      starve  <= '0;
      stall_q <= 1'b0;
    end else begin
      starve  <= starve_nxt;
      stall_q <= (starve_nxt == STARVE_TOP);
    end
  end
`else
  assign stall_q = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Randomized and directed checks of regfile_wb_arb against a queue-based
// reference model of the writeback arbiter.
module tb_regfile_wb_arb;
  localparam int DEPTH = 4;
  localparam int SMAX  = 8;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  regfile_wb_arb_if bus ();

  regfile_wb_arb #(.LL_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .cpu_clk_50M(clk),
    .cpu_rst_n  (rst_n),
    .bus        (bus)
  );

  always #10 clk = ~clk;

  // reference model state
  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_busy;
  logic        m_sberr;
  int          m_starve;
  logic        m_stall;

  task automatic model_clear();
    mq.delete();
    m_we = 0; m_wa = 0; m_wd = 0;
    m_busy = 0; m_sberr = 0; m_starve = 0; m_stall = 0;
  endtask

  task automatic set_idle();
    bus.wb_we = 0; bus.wb_wa = 0; bus.wb_wd = 0;
    bus.ll_valid = 0; bus.ll_wa = 0; bus.ll_wd = 0;
    bus.issue_valid = 0; bus.issue_wa = 0;
  endtask

  // One clock: advance the model with the inputs present at the edge.
  task automatic tick();
    ent_t        e;
    logic [31:0] old_busy;
    bit          pipe, pop, push;
    int          qsz0;
    @(posedge clk);
    old_busy = m_busy;
    qsz0 = mq.size();
    pipe = bus.wb_we && (bus.wb_wa != 0);
    push = bus.ll_valid && (qsz0 < DEPTH);
    pop = 0;
    e.wa = 0; e.wd = 0;
    m_we = 0; m_wa = 0; m_wd = 0;
    if (pipe) begin
      m_we = 1; m_wa = bus.wb_wa; m_wd = bus.wb_wd;
    end else if (qsz0 > 0) begin
      e = mq.pop_front();
      pop = 1;
      if (e.wa != 0) begin
        m_we = 1; m_wa = e.wa; m_wd = e.wd;
      end
    end
    if (push) mq.push_back('{wa: bus.ll_wa, wd: bus.ll_wd});
    if (pop) m_busy[e.wa] = 1'b0;
    if (bus.issue_valid && bus.issue_wa != 0) begin
      if (old_busy[bus.issue_wa] && !(pop && e.wa == bus.issue_wa)) m_sberr = 1;
      m_busy[bus.issue_wa] = 1'b1;
    end
    m_busy[0] = 1'b0;
`ifdef WB_STARVE_GUARD_EN
    if (qsz0 == 0 || pop) m_starve = 0;
    else if (m_starve < SMAX) m_starve++;
    m_stall = (m_starve == SMAX);
`endif
    #1;
  endtask

  task automatic apply_reset();
    #3 rst_n = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    set_idle();
    bus.ll_valid = 1; bus.ll_wa = 5'd7; bus.ll_wd = 32'hCAFE_0007;
    rst_n = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.rfwe !== 1'b0) begin bad++; $display("FAIL reset_rfwe got=%b want=0", bus.rfwe); end
    total++; if (bus.busy_mask !== 32'h0) begin bad++; $display("FAIL reset_busy got=%h want=0", bus.busy_mask); end
    total++; if (bus.ll_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.ll_ready); end
    total++; if (bus.sb_err !== 1'b0 || bus.wb_stall_req !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b want=00", bus.sb_err, bus.wb_stall_req); end
    @(negedge clk);
    rst_n = 1;
    tick();
    bus.ll_valid = 0;
    total++; if (bus.rfwe !== m_we) begin bad++; $display("FAIL first_push_rfwe got=%b want=%b", bus.rfwe, m_we); end
    tick();
    total++; if (bus.rfwe !== m_we || bus.rfwa !== m_wa || bus.rfwd !== m_wd) begin
      bad++; $display("FAIL first_push_drain got=%b/%0d/%h want=%b/%0d/%h",
                      bus.rfwe, bus.rfwa, bus.rfwd, m_we, m_wa, m_wd); end
  endtask

  task automatic test_pipe_write();
    set_idle();
    bus.wb_we = 1; bus.wb_wa = 5'd5; bus.wb_wd = 32'h1234;
    tick();
    total++; if (bus.rfwe !== m_we || bus.rfwa !== m_wa || bus.rfwd !== m_wd) begin
      bad++; $display("FAIL pipe_wr got=%b/%0d/%h want=%b/%0d/%h",
                      bus.rfwe, bus.rfwa, bus.rfwd, m_we, m_wa, m_wd); end
    bus.wb_wa = 5'd0; bus.wb_wd = 32'hFFFF;
    tick();
    total++; if (bus.rfwe !== m_we) begin bad++; $display("FAIL pipe_r0 got=%b want=%b", bus.rfwe, m_we); end
    set_idle();
  endtask

  task automatic test_ll_basic();
    set_idle();
    bus.issue_valid = 1; bus.issue_wa = 5'd9;
    tick();
    bus.issue_valid = 0;
    total++; if (bus.busy_mask !== m_busy) begin bad++; $display("FAIL ll_busy_set got=%h want=%h", bus.busy_mask, m_busy); end
    bus.ll_valid = 1; bus.ll_wa = 5'd9; bus.ll_wd = 32'hDEAD;
    tick();
    bus.ll_valid = 0;
    total++; if (bus.busy_mask !== m_busy || bus.rfwe !== m_we) begin
      bad++; $display("FAIL ll_wait got=%h/%b want=%h/%b", bus.busy_mask, bus.rfwe, m_busy, m_we); end
    tick();
    total++; if (bus.rfwe !== m_we || bus.rfwa !== m_wa || bus.rfwd !== m_wd) begin
      bad++; $display("FAIL ll_drain got=%b/%0d/%h want=%b/%0d/%h",
                      bus.rfwe, bus.rfwa, bus.rfwd, m_we, m_wa, m_wd); end
    total++; if (bus.busy_mask !== m_busy) begin bad++; $display("FAIL ll_busy_clr got=%h want=%h", bus.busy_mask, m_busy); end
  endtask

  task automatic test_fill_starve();
    set_idle();
    bus.wb_we = 1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wb_wa = 5'($urandom_range(1, 31)); bus.wb_wd = $urandom;
      bus.ll_valid = 1; bus.ll_wa = 5'(10 + i); bus.ll_wd = 32'hA000 + i;
      tick();
    end
    bus.ll_valid = 0;
    total++; if (bus.ll_ready !== (mq.size() < DEPTH)) begin
      bad++; $display("FAIL fill_ready got=%b want=%b", bus.ll_ready, mq.size() < DEPTH); end
    for (int i = 0; i < 10; i++) begin
      bus.wb_wa = 5'($urandom_range(1, 31)); bus.wb_wd = $urandom;
      tick();
      total++; if (bus.wb_stall_req !== m_stall || bus.rfwa !== m_wa) begin
        bad++; $display("FAIL starve_wait%0d got=%b/%0d want=%b/%0d", i, bus.wb_stall_req, bus.rfwa, m_stall, m_wa); end
    end
    bus.wb_we = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      tick();
      total++; if (bus.rfwe !== m_we || (m_we && (bus.rfwa !== m_wa || bus.rfwd !== m_wd))
                   || bus.wb_stall_req !== m_stall || bus.ll_ready !== (mq.size() < DEPTH)) begin
        bad++; $display("FAIL drain%0d got=%b/%0d/%h/%b want=%b/%0d/%h/%b", i, bus.rfwe, bus.rfwa,
                        bus.rfwd, bus.wb_stall_req, m_we, m_wa, m_wd, m_stall); end
    end
  endtask

  task automatic test_sb();
    set_idle();
    bus.issue_valid = 1; bus.issue_wa = 5'd3;
    bus.ll_valid = 1; bus.ll_wa = 5'd3; bus.ll_wd = 32'h33;
    tick();
    bus.ll_valid = 0;
    tick();                               // r3 pops here while r3 is re-issued
    bus.issue_valid = 0;
    total++; if (bus.sb_err !== m_sberr || bus.busy_mask[3] !== m_busy[3]) begin
      bad++; $display("FAIL sb_same_cycle got=%b/%b want=%b/%b", bus.sb_err, bus.busy_mask[3], m_sberr, m_busy[3]); end
    bus.issue_valid = 1;
    tick();
    bus.issue_valid = 0;
    total++; if (bus.sb_err !== m_sberr) begin bad++; $display("FAIL sb_double got=%b want=%b", bus.sb_err, m_sberr); end
    repeat (3) tick();
    total++; if (bus.sb_err !== m_sberr) begin bad++; $display("FAIL sb_sticky got=%b want=%b", bus.sb_err, m_sberr); end
  endtask

  task automatic test_async_reset();
    set_idle();
    bus.wb_we = 1; bus.wb_wa = 5'd4; bus.wb_wd = 32'h44;
    bus.issue_valid = 1; bus.issue_wa = 5'd20;
    bus.ll_valid = 1; bus.ll_wa = 5'd20; bus.ll_wd = 32'h2020;
    repeat (3) tick();
    set_idle();
    bus.wb_we = 1; bus.wb_wa = 5'd4;
    #4 rst_n = 0;
    model_clear();
    #1;
    total++; if (bus.rfwe !== 1'b0 || bus.busy_mask !== 32'h0 || bus.ll_ready !== 1'b1) begin
      bad++; $display("FAIL async_rst got=%b/%h/%b want=0/0/1", bus.rfwe, bus.busy_mask, bus.ll_ready); end
    set_idle();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (bus.rfwe !== m_we) begin bad++; $display("FAIL post_rst%0d got=%b want=%b", i, bus.rfwe, m_we); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.wb_we = ($urandom_range(0, 99) < 45);
      bus.wb_wa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.wb_wd = $urandom;
      bus.ll_valid = ($urandom_range(0, 99) < 50);
      bus.ll_wa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.ll_wd = $urandom;
      bus.issue_valid = ($urandom_range(0, 99) < 30);
      bus.issue_wa = 5'($urandom_range(0, 31));
      tick();
      total++; if (bus.rfwe !== m_we || (m_we && (bus.rfwa !== m_wa || bus.rfwd !== m_wd))) begin
        bad++; $display("FAIL rnd_port%0d got=%b/%0d/%h want=%b/%0d/%h", i, bus.rfwe, bus.rfwa, bus.rfwd, m_we, m_wa, m_wd); end
      total++; if (bus.busy_mask !== m_busy || bus.sb_err !== m_sberr) begin
        bad++; $display("FAIL rnd_sb%0d got=%h/%b want=%h/%b", i, bus.busy_mask, bus.sb_err, m_busy, m_sberr); end
      total++; if (bus.ll_ready !== (mq.size() < DEPTH) || bus.wb_stall_req !== m_stall) begin
        bad++; $display("FAIL rnd_flow%0d got=%b/%b want=%b/%b", i, bus.ll_ready, bus.wb_stall_req, mq.size() < DEPTH, m_stall); end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    model_clear();
    test_reset();
    test_pipe_write();
    test_ll_basic();
    apply_reset();
    test_fill_starve();
    apply_reset();
    test_sb();
    apply_reset();
    test_async_reset();
    apply_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
